mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage, upstream of writeback.
- Consumes execute's registered outputs: opcode, funct, result, store_addr, rd_addr, exception and nop fields.
- For loads and stores it runs a valid/ready data-memory transaction. It also handles misalignment, byte lanes and load extension.
- Non-memory instructions pass through in one cycle. stall_out holds execute while a transaction is outstanding.

Parameters:
- XLEN, 32, register/data width
- ADDR_W, 32, data-memory address width
- REG_ADDR_W, 5, destination register index width
- EX_W, 4, exception code width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pipeline_in_valid  in  1  execute output valid
- opcode_in  in  5  opcode (shared OP_* encodings)
- funct_in  in  3  funct3
- nop_instr_in  in  1  instruction is a NOP
- exception_in  in  EX_W  upstream exception code
- exception_in_valid  in  1  upstream exception present
- result_in  in  XLEN  ALU result; load address for LOAD, store data for STORE
- store_addr_in  in  ADDR_W  store address
- rd_addr_in  in  REG_ADDR_W  destination register
- flush_in  in  1  kill the in-flight instruction
- stall_out  out  1  hold execute
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- dmem_wdata  out  XLEN  lane-replicated write data
- dmem_wstrb  out  4  byte enables
- dmem_resp_valid  in  1  response valid (loads and stores)
- dmem_rdata  in  XLEN  read word
- pipeline_out_valid  out  1  one-cycle pulse per retired instruction
- wb_en  out  1  write rd
- wb_data  out  XLEN  writeback value
- rd_addr_out  out  REG_ADDR_W  destination register
- exception_out  out  EX_W  exception code
- exception_out_valid  out  1  exception present

Behaviour:
- Reset (reset=0, async): FSM=IDLE; all outputs 0, including dmem_* outputs and stall_out.
- FSM states: IDLE, REQ, WAIT.
- IDLE, with valid, no flush, no exception, not NOP, opcode LOAD/STORE and aligned: latch fields and go to REQ.
- All other valid instructions in IDLE: registered pass-through next cycle with pipeline_out_valid=1.
  - wb_en=1 for ARITH, IMM_ARITH, LUI, AUIPC, JAL, JALR when rd≠0 and no exception.
  - wb_data=result_in.
- REQ: dmem_req_valid=1; address, data and strobe are held stable until ready. On ready go to WAIT.
- WAIT: on dmem_resp_valid go to IDLE, with pipeline_out_valid=1 next cycle. Responses seen outside WAIT are ignored.
- stall_out = (state≠IDLE), combinational.
- Minimum memory latency: accept at T, request at T+1, response at T+2, output registered at T+3.
- Alignment:
  - halfword needs addr[0]=0; word needs addr[1:0]=0.
  - Misaligned load → exception 4; misaligned store → exception 6.
  - On misalignment: no memory access, one-cycle pass-through, wb_en=0.
- Invalid funct:
  - load funct other than 000, 001, 010, 100, 101 → exception 2.
  - store funct other than 000, 001, 010 → exception 2.
- Store strobes: SB 0001<<a[1:0]; SH 0011<<a[1:0]; SW 1111. Data replicated across lanes.
- Load extraction: select lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
- Upstream exception_in_valid: passed through unchanged, wb_en=0, no memory access.
- NOP: pipeline_out_valid=1, wb_en=0.
- flush_in:
  - IDLE: the input is discarded.
  - REQ: the request is withdrawn the same cycle and FSM returns to IDLE. The memory interface permits withdrawal before ready.
  - WAIT: the transaction completes, then the response is dropped with no pipeline_out_valid. A store already accepted stays committed.
- flush_in also clears pipeline_out_valid on the next edge.
- Reset mid-transaction: immediate return to IDLE. The memory side must tolerate an abandoned request.

Decomposition:
- Shared definitions package holds:
  - OP_* opcodes
  - F3 load/store encodings: LB, LH, LW, LBU, LHU, SB, SH, SW
  - exception codes: 2 illegal, 4 load misaligned, 6 store misaligned
  - FSM state encodings
- One sub-module: mem_align, combinational. It generates strobes and write-data replication, extracts and extends load data, and flags misalignment.

Test Plan:
- ADD passthrough: result_in=0x1234, rd=5 → next cycle pipeline_out_valid=1, wb_en=1, wb_data=0x1234, rd_addr_out=5, no memory request.
- LB at 0x1003, rdata=0x80FF_FF00 → wstrb ignored, dmem_addr=0x1000, wb_data=0xFFFF_FF80. With LBU → 0x0000_0080.
- SH at 0x2002 with data 0xABCD → dmem_we=1, wstrb=1100, wdata=0xABCD_ABCD. Hold ready=0 for 3 cycles: request stable and stall_out=1 throughout.
- LW at 0x3001 → no request, exception_out=4, exception_out_valid=1, wb_en=0, one-cycle latency.
- SW with flush_in asserted in REQ (ready=0) → dmem_req_valid drops, no pipeline_out_valid. Flush in WAIT → response consumed, no output.
- Reset deasserted then asserted mid-WAIT → all outputs 0 asynchronously; the next LW completes normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: opcodes, load/store funct3 values,
// exception codes and the FSM state type.
package mem_stage_pkg;

  localparam logic [4:0] OP_LOAD      = 5'b00000;
  localparam logic [4:0] OP_IMM_ARITH = 5'b00100;
  localparam logic [4:0] OP_AUIPC     = 5'b00101;
  localparam logic [4:0] OP_STORE     = 5'b01000;
  localparam logic [4:0] OP_ARITH     = 5'b01100;
  localparam logic [4:0] OP_LUI       = 5'b01101;
  localparam logic [4:0] OP_BRANCH    = 5'b11000;
  localparam logic [4:0] OP_JALR      = 5'b11001;
  localparam logic [4:0] OP_JAL       = 5'b11011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] EXC_ILLEGAL          = 4'd2;
  localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Instructions that produce a register result in a single pass-through cycle.
  function automatic logic writesRd(input logic [4:0] op);
    return (op == OP_ARITH) || (op == OP_IMM_ARITH) || (op == OP_LUI) ||
           (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory valid/ready bus between the memory stage (master) and the
// data memory (slave).
interface mem_stage_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [3:0]        wstrb;
  logic              resp_valid;
  logic [XLEN-1:0]   rdata;

  modport master (
    output req_valid, we, addr, wdata, wstrb,
    input  req_ready, resp_valid, rdata
  );

  modport slave (
    input  req_valid, we, addr, wdata, wstrb,
    output req_ready, resp_valid, rdata
  );

endinterface

// File: rtl/mem_stage_align.sv
// Combinational byte-lane logic: store strobes and lane replication, load lane
// extraction with sign/zero extension, misalignment and funct3 legality.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic        i_isStore,
  input  logic [2:0]  i_funct,
  input  logic [1:0]  i_addrLo,
  input  logic [31:0] i_storeData,
  input  logic [31:0] i_readData,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_loadData,
  output logic        o_misaligned,
  output logic        o_illegal
);

  logic [31:0] w_shifted;

  // Bring the addressed lane down to bit 0 so extraction is lane-independent.
  assign w_shifted = i_readData >> {i_addrLo, 3'b000};

  always_comb begin
    o_illegal    = 1'b0;
    o_misaligned = 1'b0;
    o_wstrb      = 4'b1111;
    o_wdata      = i_storeData;
    o_loadData   = w_shifted;

    if (i_isStore)
      o_illegal = !((i_funct == F3_SB) || (i_funct == F3_SH) || (i_funct == F3_SW));
    else
      o_illegal = !((i_funct == F3_LB) || (i_funct == F3_LH) || (i_funct == F3_LW) ||
                    (i_funct == F3_LBU) || (i_funct == F3_LHU));

    case (i_funct[1:0])
      2'b00: begin
        o_misaligned = 1'b0;
        o_wstrb      = 4'b0001 << i_addrLo;
        o_wdata      = {4{i_storeData[7:0]}};
      end
      2'b01: begin
        o_misaligned = i_addrLo[0];
        o_wstrb      = 4'b0011 << i_addrLo;
        o_wdata      = {2{i_storeData[15:0]}};
      end
      default: begin
        o_misaligned = |i_addrLo;
        o_wstrb      = 4'b1111;
        o_wdata      = i_storeData;
      end
    endcase

    case (i_funct)
      F3_LB:   o_loadData = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LBU:  o_loadData = {24'h0, w_shifted[7:0]};
      F3_LH:   o_loadData = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LHU:  o_loadData = {16'h0, w_shifted[15:0]};
      default: o_loadData = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes non-memory instructions through in one
// cycle and runs a valid/ready data-memory transaction for loads and stores.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int EX_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipeline_in_valid,
  input  logic [4:0]            opcode_in,
  input  logic [2:0]            funct_in,
  input  logic                  nop_instr_in,
  input  logic [EX_W-1:0]       exception_in,
  input  logic                  exception_in_valid,
  input  logic [XLEN-1:0]       result_in,
  input  logic [ADDR_W-1:0]     store_addr_in,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic                  flush_in,
  output logic                  stall_out,
  mem_stage_if.master           dmem,
  output logic                  pipeline_out_valid,
  output logic                  wb_en,
  output logic [XLEN-1:0]       wb_data,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic [EX_W-1:0]       exception_out,
  output logic                  exception_out_valid
);

  state_t                r_state;
  logic                  r_isStore;
  logic [2:0]            r_funct;
  logic [1:0]            r_addrLo;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_flushed;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [XLEN-1:0]       r_wdata;
  logic [3:0]            r_wstrb;

  logic              w_inIsStore;
  logic              w_inIsMem;
  logic [ADDR_W-1:0] w_inAddr;
  logic              w_alignIsStore;
  logic [2:0]        w_alignFunct;
  logic [1:0]        w_alignAddrLo;
  logic [3:0]        w_alignWstrb;
  logic [XLEN-1:0]   w_alignWdata;
  logic [XLEN-1:0]   w_alignLoad;
  logic              w_misaligned;
  logic              w_illegal;

  assign w_inIsStore = (opcode_in == OP_STORE);
  assign w_inIsMem   = w_inIsStore || (opcode_in == OP_LOAD);
  assign w_inAddr    = w_inIsStore ? store_addr_in : result_in[ADDR_W-1:0];

  // In IDLE the aligner inspects the incoming instruction; afterwards it
  // works on the latched load so the response can be extracted in WAIT.
  assign w_alignIsStore = (r_state == ST_IDLE) ? w_inIsStore   : r_isStore;
  assign w_alignFunct   = (r_state == ST_IDLE) ? funct_in      : r_funct;
  assign w_alignAddrLo  = (r_state == ST_IDLE) ? w_inAddr[1:0] : r_addrLo;

  mem_align u_align (
    .i_isStore    (w_alignIsStore),
    .i_funct      (w_alignFunct),
    .i_addrLo     (w_alignAddrLo),
    .i_storeData  (result_in),
    .i_readData   (dmem.rdata),
    .o_wstrb      (w_alignWstrb),
    .o_wdata      (w_alignWdata),
    .o_loadData   (w_alignLoad),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  assign stall_out      = (r_state != ST_IDLE);
  assign dmem.req_valid = (r_state == ST_REQ) && !flush_in;
  assign dmem.we        = r_we;
  assign dmem.addr      = r_addr;
  assign dmem.wdata     = r_wdata;
  assign dmem.wstrb     = r_wstrb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state             <= ST_IDLE;
      r_isStore           <= 1'b0;
      r_funct             <= '0;
      r_addrLo            <= '0;
      r_rd                <= '0;
      r_flushed           <= 1'b0;
      r_we                <= 1'b0;
      r_addr              <= '0;
      r_wdata             <= '0;
      r_wstrb             <= '0;
      pipeline_out_valid  <= 1'b0;
      wb_en               <= 1'b0;
      wb_data             <= '0;
      rd_addr_out         <= '0;
      exception_out       <= '0;
      exception_out_valid <= 1'b0;
    end else begin
      pipeline_out_valid  <= 1'b0;
      wb_en               <= 1'b0;
      exception_out_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (pipeline_in_valid && !flush_in) begin
            rd_addr_out   <= rd_addr_in;
            wb_data       <= result_in;
            exception_out <= '0;
            if (exception_in_valid) begin
              pipeline_out_valid  <= 1'b1;
              exception_out       <= exception_in;
              exception_out_valid <= 1'b1;
            end else if (nop_instr_in) begin
              pipeline_out_valid <= 1'b1;
            end else if (w_inIsMem) begin
              if (w_illegal) begin
                pipeline_out_valid  <= 1'b1;
                exception_out       <= EX_W'(EXC_ILLEGAL);
                exception_out_valid <= 1'b1;
              end else if (w_misaligned) begin
                pipeline_out_valid  <= 1'b1;
                exception_out       <= w_inIsStore ? EX_W'(EXC_STORE_MISALIGNED)
                                                   : EX_W'(EXC_LOAD_MISALIGNED);
                exception_out_valid <= 1'b1;
              end else begin
                r_state   <= ST_REQ;
                r_isStore <= w_inIsStore;
                r_funct   <= funct_in;
                r_addrLo  <= w_inAddr[1:0];
                r_rd      <= rd_addr_in;
                r_flushed <= 1'b0;
                r_we      <= w_inIsStore;
                r_addr    <= {w_inAddr[ADDR_W-1:2], 2'b00};
                r_wdata   <= w_inIsStore ? w_alignWdata : '0;
                r_wstrb   <= w_inIsStore ? w_alignWstrb : 4'b0000;
              end
            end else begin
              pipeline_out_valid <= 1'b1;
              wb_en              <= writesRd(opcode_in) && (rd_addr_in != '0);
            end
          end
        end

        ST_REQ: begin
          // A flush withdraws the request before any handshake can happen.
          if (flush_in || dmem.req_ready) begin
            r_state <= flush_in ? ST_IDLE : ST_WAIT;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
          end
        end

        ST_WAIT: begin
          if (flush_in)
            r_flushed <= 1'b1;
          if (dmem.resp_valid) begin
            r_state   <= ST_IDLE;
            r_flushed <= 1'b0;
            if (!r_flushed && !flush_in) begin
              pipeline_out_valid <= 1'b1;
              rd_addr_out        <= r_rd;
              exception_out      <= '0;
              wb_en              <= !r_isStore && (r_rd != '0);
              wb_data            <= r_isStore ? '0 : w_alignLoad;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: a vector table for the
// single-cycle paths plus hand-written sequences for memory transactions.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipeline_in_valid;
  logic [4:0]  opcode_in;
  logic [2:0]  funct_in;
  logic        nop_instr_in;
  logic [3:0]  exception_in;
  logic        exception_in_valid;
  logic [31:0] result_in;
  logic [31:0] store_addr_in;
  logic [4:0]  rd_addr_in;
  logic        flush_in;
  logic        stall_out;
  logic        pipeline_out_valid;
  logic        wb_en;
  logic [31:0] wb_data;
  logic [4:0]  rd_addr_out;
  logic [3:0]  exception_out;
  logic        exception_out_valid;

  int checkCount = 0;
  int passCount  = 0;

  mem_stage_if dmemBus ();

  mem_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .pipeline_in_valid   (pipeline_in_valid),
    .opcode_in           (opcode_in),
    .funct_in            (funct_in),
    .nop_instr_in        (nop_instr_in),
    .exception_in        (exception_in),
    .exception_in_valid  (exception_in_valid),
    .result_in           (result_in),
    .store_addr_in       (store_addr_in),
    .rd_addr_in          (rd_addr_in),
    .flush_in            (flush_in),
    .stall_out           (stall_out),
    .dmem                (dmemBus),
    .pipeline_out_valid  (pipeline_out_valid),
    .wb_en               (wb_en),
    .wb_data             (wb_data),
    .rd_addr_out         (rd_addr_out),
    .exception_out       (exception_out),
    .exception_out_valid (exception_out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  opcode;
    logic [2:0]  funct;
    logic        nop;
    logic        excValid;
    logic [3:0]  exc;
    logic [31:0] result;
    logic [31:0] storeAddr;
    logic [4:0]  rd;
    logic        flush;
    logic        expPov;
    logic        expWbEn;
    logic [3:0]  expExc;
    logic        expExcValid;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else
      passCount++;
  endtask

  // Presents one instruction for one edge, then returns #1 after that edge.
  task automatic applyStimulus(input logic [4:0] op, input logic [2:0] f, input logic nop,
                               input logic excV, input logic [3:0] exc, input logic [31:0] res,
                               input logic [31:0] sAddr, input logic [4:0] rd, input logic fl);
    @(negedge clk);
    pipeline_in_valid  = 1'b1;
    opcode_in          = op;
    funct_in           = f;
    nop_instr_in       = nop;
    exception_in_valid = excV;
    exception_in       = exc;
    result_in          = res;
    store_addr_in      = sAddr;
    rd_addr_in         = rd;
    flush_in           = fl;
    @(posedge clk);
    #1;
    pipeline_in_valid  = 1'b0;
    flush_in           = 1'b0;
  endtask

  // One ready cycle followed by one response cycle.
  task automatic completeTxn(input logic [31:0] rdata);
    @(negedge clk);
    dmemBus.req_ready = 1'b1;
    @(posedge clk);
    #1;
    dmemBus.req_ready = 1'b0;
    @(negedge clk);
    dmemBus.resp_valid = 1'b1;
    dmemBus.rdata      = rdata;
    @(posedge clk);
    #1;
    dmemBus.resp_valid = 1'b0;
  endtask

  task automatic addVec(input string n, input logic [4:0] op, input logic [2:0] f, input logic nop,
                        input logic excV, input logic [3:0] exc, input logic [31:0] res,
                        input logic [31:0] sAddr, input logic [4:0] rd, input logic fl,
                        input logic pov, input logic wbEn, input logic [3:0] eExc, input logic eExcV);
    vec_t v;
    v.name = n; v.opcode = op; v.funct = f; v.nop = nop; v.excValid = excV; v.exc = exc;
    v.result = res; v.storeAddr = sAddr; v.rd = rd; v.flush = fl;
    v.expPov = pov; v.expWbEn = wbEn; v.expExc = eExc; v.expExcValid = eExcV;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    pipeline_in_valid = 1'b0; opcode_in = '0; funct_in = '0; nop_instr_in = 1'b0;
    exception_in = '0; exception_in_valid = 1'b0; result_in = '0; store_addr_in = '0;
    rd_addr_in = '0; flush_in = 1'b0;
    dmemBus.req_ready = 1'b0; dmemBus.resp_valid = 1'b0; dmemBus.rdata = '0;

    addVec("add",        OP_ARITH,     3'b000, 0, 0, 4'h0, 32'h0000_1234, 32'h0, 5'd5,  0, 1, 1, 4'h0, 0);
    addVec("addi_x0",    OP_IMM_ARITH, 3'b000, 0, 0, 4'h0, 32'h0000_0055, 32'h0, 5'd0,  0, 1, 0, 4'h0, 0);
    addVec("branch",     OP_BRANCH,    3'b000, 0, 0, 4'h0, 32'h0000_0001, 32'h0, 5'd3,  0, 1, 0, 4'h0, 0);
    addVec("lw_mis",     OP_LOAD,      F3_LW,  0, 0, 4'h0, 32'h0000_3001, 32'h0, 5'd7,  0, 1, 0, 4'h4, 1);
    addVec("sh_mis",     OP_STORE,     F3_SH,  0, 0, 4'h0, 32'h0000_ABCD, 32'h0000_2001, 5'd0, 0, 1, 0, 4'h6, 1);
    addVec("sw_mis",     OP_STORE,     F3_SW,  0, 0, 4'h0, 32'h1111_2222, 32'h0000_2002, 5'd0, 0, 1, 0, 4'h6, 1);
    addVec("lh_mis",     OP_LOAD,      F3_LH,  0, 0, 4'h0, 32'h0000_1001, 32'h0, 5'd2,  0, 1, 0, 4'h4, 1);
    addVec("ld_badf3",   OP_LOAD,      3'b011, 0, 0, 4'h0, 32'h0000_1000, 32'h0, 5'd2,  0, 1, 0, 4'h2, 1);
    addVec("st_badf3",   OP_STORE,     3'b100, 0, 0, 4'h0, 32'h0000_0000, 32'h0000_1000, 5'd0, 0, 1, 0, 4'h2, 1);
    addVec("upstream",   OP_LOAD,      F3_LW,  0, 1, 4'h5, 32'h0000_1000, 32'h0, 5'd8,  0, 1, 0, 4'h5, 1);
    addVec("nop",        OP_ARITH,     3'b000, 1, 0, 4'h0, 32'h0000_0099, 32'h0, 5'd3,  0, 1, 0, 4'h0, 0);
    addVec("jal",        OP_JAL,       3'b000, 0, 0, 4'h0, 32'h0000_0104, 32'h0, 5'd1,  0, 1, 1, 4'h0, 0);
    addVec("lui",        OP_LUI,       3'b000, 0, 0, 4'h0, 32'hDEAD_0000, 32'h0, 5'd31, 0, 1, 1, 4'h0, 0);
    addVec("flush_idle", OP_ARITH,     3'b000, 0, 0, 4'h0, 32'h0000_7777, 32'h0, 5'd9,  1, 0, 0, 4'h0, 0);
    addVec("ld_flush",   OP_LOAD,      F3_LW,  0, 0, 4'h0, 32'h0000_1000, 32'h0, 5'd9,  1, 0, 0, 4'h0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.pov",   {31'h0, pipeline_out_valid}, 32'h0);
    checkOutput("rst.wb_en", {31'h0, wb_en},              32'h0);
    checkOutput("rst.wbdat", wb_data,                     32'h0);
    checkOutput("rst.rd",    {27'h0, rd_addr_out},        32'h0);
    checkOutput("rst.exc",   {27'h0, exception_out_valid, exception_out}, 32'h0);
    checkOutput("rst.req",   {31'h0, dmemBus.req_valid},  32'h0);
    checkOutput("rst.we",    {31'h0, dmemBus.we},         32'h0);
    checkOutput("rst.addr",  dmemBus.addr,                32'h0);
    checkOutput("rst.wdata", dmemBus.wdata,               32'h0);
    checkOutput("rst.wstrb", {28'h0, dmemBus.wstrb},      32'h0);
    checkOutput("rst.stall", {31'h0, stall_out},          32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Single-cycle table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].opcode, vecs[i].funct, vecs[i].nop, vecs[i].excValid, vecs[i].exc,
                    vecs[i].result, vecs[i].storeAddr, vecs[i].rd, vecs[i].flush);
      checkOutput({vecs[i].name, ".pov"},   {31'h0, pipeline_out_valid},  {31'h0, vecs[i].expPov});
      checkOutput({vecs[i].name, ".wb_en"}, {31'h0, wb_en},               {31'h0, vecs[i].expWbEn});
      checkOutput({vecs[i].name, ".excv"},  {31'h0, exception_out_valid}, {31'h0, vecs[i].expExcValid});
      checkOutput({vecs[i].name, ".req"},   {31'h0, dmemBus.req_valid},   32'h0);
      checkOutput({vecs[i].name, ".stall"}, {31'h0, stall_out},           32'h0);
      if (vecs[i].expPov) begin
        checkOutput({vecs[i].name, ".rd"},  {27'h0, rd_addr_out},   {27'h0, vecs[i].rd});
        checkOutput({vecs[i].name, ".exc"}, {28'h0, exception_out}, {28'h0, vecs[i].expExc});
      end
      if (vecs[i].expWbEn)
        checkOutput({vecs[i].name, ".wbdat"}, wb_data, vecs[i].result);
    end
    @(posedge clk);
    #1;
    checkOutput("pulse.pov", {31'h0, pipeline_out_valid}, 32'h0);

    // LB / LBU at 0x1003
    applyStimulus(OP_LOAD, F3_LB, 0, 0, 4'h0, 32'h0000_1003, 32'h0, 5'd9, 0);
    checkOutput("lb.req",   {31'h0, dmemBus.req_valid}, 32'h1);
    checkOutput("lb.we",    {31'h0, dmemBus.we},        32'h0);
    checkOutput("lb.addr",  dmemBus.addr,               32'h0000_1000);
    checkOutput("lb.stall", {31'h0, stall_out},         32'h1);
    completeTxn(32'h80FF_FF00);
    checkOutput("lb.pov",   {31'h0, pipeline_out_valid}, 32'h1);
    checkOutput("lb.wb_en", {31'h0, wb_en},              32'h1);
    checkOutput("lb.wbdat", wb_data,                     32'hFFFF_FF80);
    checkOutput("lb.rd",    {27'h0, rd_addr_out},        32'd9);
    checkOutput("lb.stall", {31'h0, stall_out},          32'h0);
    applyStimulus(OP_LOAD, F3_LBU, 0, 0, 4'h0, 32'h0000_1003, 32'h0, 5'd10, 0);
    completeTxn(32'h80FF_FF00);
    checkOutput("lbu.wbdat", wb_data, 32'h0000_0080);
    applyStimulus(OP_LOAD, F3_LH, 0, 0, 4'h0, 32'h0000_1002, 32'h0, 5'd11, 0);
    completeTxn(32'h8001_7FFF);
    checkOutput("lh.wbdat", wb_data, 32'hFFFF_8001);

    // SH at 0x2002 with ready held low
    applyStimulus(OP_STORE, F3_SH, 0, 0, 4'h0, 32'h0000_ABCD, 32'h0000_2002, 5'd0, 0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("sh.req",   {31'h0, dmemBus.req_valid}, 32'h1);
      checkOutput("sh.we",    {31'h0, dmemBus.we},        32'h1);
      checkOutput("sh.addr",  dmemBus.addr,               32'h0000_2000);
      checkOutput("sh.wdata", dmemBus.wdata,              32'hABCD_ABCD);
      checkOutput("sh.wstrb", {28'h0, dmemBus.wstrb},     32'hC);
      checkOutput("sh.stall", {31'h0, stall_out},         32'h1);
      @(posedge clk);
      #1;
    end
    completeTxn(32'h0);
    checkOutput("sh.pov",   {31'h0, pipeline_out_valid}, 32'h1);
    checkOutput("sh.wb_en", {31'h0, wb_en},              32'h0);
    applyStimulus(OP_STORE, F3_SB, 0, 0, 4'h0, 32'h0000_005A, 32'h0000_2001, 5'd0, 0);
    checkOutput("sb.wstrb", {28'h0, dmemBus.wstrb}, 32'h2);
    checkOutput("sb.wdata", dmemBus.wdata,          32'h5A5A_5A5A);
    completeTxn(32'h0);

    // SW flushed in REQ
    applyStimulus(OP_STORE, F3_SW, 0, 0, 4'h0, 32'h1122_3344, 32'h0000_4000, 5'd0, 0);
    checkOutput("swfl.req0", {31'h0, dmemBus.req_valid}, 32'h1);
    @(negedge clk);
    flush_in = 1'b1;
    #1;
    checkOutput("swfl.req1", {31'h0, dmemBus.req_valid}, 32'h0);
    @(posedge clk);
    #1;
    flush_in = 1'b0;
    checkOutput("swfl.stall", {31'h0, stall_out},          32'h0);
    checkOutput("swfl.pov",   {31'h0, pipeline_out_valid}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("swfl.pov2",  {31'h0, pipeline_out_valid}, 32'h0);

    // LW flushed in WAIT
    applyStimulus(OP_LOAD, F3_LW, 0, 0, 4'h0, 32'h0000_3000, 32'h0, 5'd4, 0);
    @(negedge clk);
    dmemBus.req_ready = 1'b1;
    @(posedge clk);
    #1;
    dmemBus.req_ready = 1'b0;
    @(negedge clk);
    flush_in = 1'b1;
    @(posedge clk);
    #1;
    flush_in = 1'b0;
    checkOutput("lwfl.stall", {31'h0, stall_out},          32'h1);
    checkOutput("lwfl.pov",   {31'h0, pipeline_out_valid}, 32'h0);
    @(negedge clk);
    dmemBus.resp_valid = 1'b1;
    dmemBus.rdata      = 32'h1234_5678;
    @(posedge clk);
    #1;
    dmemBus.resp_valid = 1'b0;
    checkOutput("lwfl.pov2",   {31'h0, pipeline_out_valid}, 32'h0);
    checkOutput("lwfl.stall2", {31'h0, stall_out},          32'h0);

    // Reset mid-WAIT, then a clean LW
    applyStimulus(OP_LOAD, F3_LW, 0, 0, 4'h0, 32'h0000_3000, 32'h0, 5'd6, 0);
    @(negedge clk);
    dmemBus.req_ready = 1'b1;
    @(posedge clk);
    #1;
    dmemBus.req_ready = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst.stall", {31'h0, stall_out},         32'h0);
    checkOutput("arst.req",   {31'h0, dmemBus.req_valid}, 32'h0);
    checkOutput("arst.wbdat", wb_data,                    32'h0);
    checkOutput("arst.rd",    {27'h0, rd_addr_out},       32'h0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(OP_LOAD, F3_LW, 0, 0, 4'h0, 32'h0000_5004, 32'h0, 5'd6, 0);
    checkOutput("lw.addr", dmemBus.addr, 32'h0000_5004);
    completeTxn(32'hCAFE_BABE);
    checkOutput("lw.pov",   {31'h0, pipeline_out_valid}, 32'h1);
    checkOutput("lw.wb_en", {31'h0, wb_en},              32'h1);
    checkOutput("lw.wbdat", wb_data,                     32'hCAFE_BABE);
    checkOutput("lw.rd",    {27'h0, rd_addr_out},        32'd6);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
